mc_control: RTL and testbench
=============================

Name: mc_control

Overview:
- Multi-cycle successor to the single-cycle MIPS32 control decoder: an FSM that sequences fetch, decode, execute, memory and writeback over several clocks.
- Talks to a memory with a ready handshake and to an iterative mul/div unit with configurable latency.
- Sits between the instruction register (op/funct/rt fields) and the shared multi-cycle datapath (PC, IR, register file, ALU, HI/LO).

Parameters:
- ALUOP_W, 5, width of alu_op.
- MUL_CYCLES, 4, cycles md_busy is held for mult/multu (must be >=1).
- DIV_CYCLES, 32, cycles md_busy is held for div/divu (must be >=1).
- MEM_TIMEOUT, 15, max cycles to wait for mem_ready before bus_err (must be >=1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- op  in  6  instr[31:26].
- funct  in  6  instr[5:0].
- rt_field  in  5  instr[20:16]; selects bgez/bltz under op 000001.
- br_taken  in  1  datapath compare result, valid in S_BRANCH.
- mem_ready  in  1  memory completion for the current request.
- mem_req  out  1  memory request, held until accepted.
- mem_we  out  1  1 = write.
- mem_byte  out  1  1 = byte access (lb/lbu/sb).
- mem_uns  out  1  1 = zero-extend the load (lbu).
- iord  out  1  0 = PC address, 1 = ALU address.
- ir_we  out  1  latch instruction.
- pc_we  out  1  PC write enable.
- pc_src  out  2  0 = pc+4, 1 = branch target, 2 = jump target.
- reg_we  out  1  register file write.
- reg_dst  out  2  0 = rt, 1 = rd, 2 = $31.
- wb_src  out  2  0 = ALU out, 1 = mem data, 2 = pc+4.
- alu_src_b  out  2  0 = reg rt, 1 = ext imm, 2 = const 4.
- ext_op  out  1  1 = sign-extend imm.
- alu_op  out  ALUOP_W  ALU operation code.
- md_start  out  1  one-cycle start pulse to the mul/div unit.
- md_busy  out  1  high while mul/div is running.
- hilo_we  out  1  one-cycle HI/LO write at mul/div completion.
- illegal  out  1  one-cycle pulse on an unknown opcode.
- bus_err  out  1  one-cycle pulse on a memory timeout.
- state  out  4  current state, for debug.

Behaviour:
- State register plus op_q/funct_q/rt_q, all latched in S_DECODE. Outputs are decoded combinationally from the state and the latched fields.
- While rst is high: state = S_FETCH, every output 0, all counters 0. This includes mem_req; the request is dropped immediately even mid-transaction.
- S_FETCH:
  - mem_req=1, iord=0, alu_src_b=2, alu_op=00000.
  - On mem_ready: ir_we=1, pc_we=1, pc_src=0, then go to S_DECODE.
- S_DECODE (op/funct/rt_field sampled here):
  - j: pc_we=1, pc_src=2, go to S_FETCH.
  - jal: same as j, plus reg_we=1, reg_dst=2, wb_src=2.
  - R-type mult/multu/div/divu (funct 011000/011001/011010/011011): md_start=1, go to S_MULDIV.
  - Other R-type: go to S_EXEC_R.
  - I-type ALU ops: go to S_EXEC_I.
  - lw/sw/lb/lbu/sb: go to S_ADDR.
  - beq/bne/bgez/bltz/bgtz/blez: go to S_BRANCH.
  - Anything else: illegal=1, go to S_FETCH.
- S_EXEC_R:
  - alu_src_b=0, alu_op=01111 (ALU decodes funct).
  - reg_we=1, reg_dst=1, wb_src=0, go to S_FETCH (writeback merged).
- S_EXEC_I:
  - alu_src_b=1; reg_we=1, reg_dst=0, wb_src=0.
  - alu_op: addiu 00000, slti 00010, sltiu 01001, andi 00011, ori 00101, xori 00110, lui 10000.
  - ext_op=1 for addiu/slti/sltiu, else 0.
  - Go to S_FETCH.
- S_ADDR: alu_src_b=1, ext_op=1, alu_op=00000, go to S_MEM.
- S_MEM:
  - mem_req=1, iord=1, mem_we=1 for sw/sb.
  - mem_byte=1 for lb/lbu/sb; mem_uns=1 for lbu.
  - On mem_ready: a load goes to S_WB, a store goes to S_FETCH.
- S_WB: reg_we=1, reg_dst=0, wb_src=1, go to S_FETCH.
- S_BRANCH:
  - alu_src_b=0 for beq/bne, else don't-care.
  - alu_op: beq/bne 00001, bgez 10001, bgtz 10010, blez 10011, bltz 10100.
  - pc_we=br_taken, pc_src=1, go to S_FETCH.
- S_MULDIV:
  - md_busy=1; counter loads MUL_CYCLES-1 or DIV_CYCLES-1 on md_start.
  - Counter decrements each cycle. At 0: hilo_we=1, go to S_FETCH.
- Memory handshake (S_FETCH and S_MEM):
  - mem_req, mem_we, mem_byte, mem_uns and iord are stable until mem_ready is sampled high.
  - mem_ready while mem_req=0 is ignored.
  - A wait counter resets on state entry. If MEM_TIMEOUT cycles elapse without ready: bus_err=1, no write enables, go to S_FETCH (retry fetch).
  - mem_ready on the timeout cycle counts as success.
- Instruction latencies with zero-wait memory:
  - j/jal: 2 cycles.
  - branch: 3 cycles.
  - R-type, I-type ALU and store: 3, 3 and 4 cycles respectively.
  - load: 5 cycles.
  - mul/div: 2+N cycles, N = MUL_CYCLES or DIV_CYCLES.
- No two write enables (pc_we with ir_we aside) conflict; pc_we and reg_we are never both high except for jal.

Test Plan:
- addiu (op 001001), mem_ready tied 1 -> states FETCH, DECODE, EXEC_I; reg_we=1 only in cycle 3; alu_op=00000; ext_op=1.
- lw (op 100011), data mem_ready delayed 3 cycles -> mem_req=1 and iord=1 held for 4 cycles; then S_WB with wb_src=1, reg_we=1; 8 cycles total.
- beq with br_taken=1, then with br_taken=0 -> pc_we=1, pc_src=1 in S_BRANCH for the first; pc_we=0 for the second; alu_op=00001 in both.
- div (funct 011010), DIV_CYCLES=32 -> md_start pulse in DECODE; md_busy high exactly 32 cycles; hilo_we on the last; then FETCH.
- op 111111 -> illegal pulses 1 cycle in DECODE; no reg_we/pc_we; next state FETCH. Fetch with mem_ready never high -> bus_err after 15 cycles.
- rst asserted mid-S_MULDIV and mid-S_MEM -> all outputs 0 in the same cycle (async); state=FETCH; mem_req asserted first clock after release.

Source files
------------

// File: rtl/mc_control.sv
// Multi-cycle MIPS32 control FSM: sequences fetch, decode, execute, memory and writeback
// over several clocks, with a ready-handshake memory port and an iterative mul/div unit.
module mc_control #(
  parameter int ALUOP_W     = 5,
  parameter int MUL_CYCLES  = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic [4:0]         rt_field,
  input  logic               br_taken,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               mem_byte,
  output logic               mem_uns,
  output logic               iord,
  output logic               ir_we,
  output logic               pc_we,
  output logic [1:0]         pc_src,
  output logic               reg_we,
  output logic [1:0]         reg_dst,
  output logic [1:0]         wb_src,
  output logic [1:0]         alu_src_b,
  output logic               ext_op,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               md_start,
  output logic               md_busy,
  output logic               hilo_we,
  output logic               illegal,
  output logic               bus_err,
  output logic [3:0]         state
);
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2, S_EXEC_I = 4'd3, S_ADDR = 4'd4,
    S_MEM    = 4'd5, S_WB     = 4'd6, S_BRANCH = 4'd7, S_MULDIV = 4'd8
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_REGIMM = 6'b000001, OP_J = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011, OP_BEQ = 6'b000100, OP_BNE = 6'b000101;
  localparam logic [5:0] OP_BLEZ = 6'b000110, OP_BGTZ = 6'b000111, OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI = 6'b001010, OP_SLTIU = 6'b001011, OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI = 6'b001101, OP_XORI = 6'b001110, OP_LUI = 6'b001111;
  localparam logic [5:0] OP_LB = 6'b100000, OP_LW = 6'b100011, OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SB = 6'b101000, OP_SW = 6'b101011;

  localparam int MD_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int MD_W   = (MD_MAX > 1) ? $clog2(MD_MAX) : 1;
  localparam int TO_W   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t            state_q, state_d;
  logic [5:0]        op_q, op_d;
  logic [4:0]        rt_q, rt_d;
  logic [MD_W-1:0]   md_cnt_q, md_cnt_d;
  logic [TO_W-1:0]   wait_q, wait_d;
  logic              is_store, is_mul, is_div;

  // Memory handshake: mem_req is the valid, mem_ready the ready; a transfer completes on
  // a cycle where both are high, and every request attribute holds steady until then.
  assign is_store = (op_q == OP_SW) || (op_q == OP_SB);
  assign is_mul   = (funct == 6'b011000) || (funct == 6'b011001);
  assign is_div   = (funct == 6'b011010) || (funct == 6'b011011);
  assign state    = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      op_q     <= '0;
      rt_q     <= '0;
      md_cnt_q <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rt_q     <= rt_d;
      md_cnt_q <= md_cnt_d;
      wait_q   <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q; op_d = op_q; rt_d = rt_q; md_cnt_d = md_cnt_q; wait_d = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_byte = 1'b0; mem_uns = 1'b0; iord = 1'b0;
    ir_we = 1'b0; pc_we = 1'b0; pc_src = 2'd0; reg_we = 1'b0; reg_dst = 2'd0;
    wb_src = 2'd0; alu_src_b = 2'd0; ext_op = 1'b0; alu_op = '0;
    md_start = 1'b0; md_busy = 1'b0; hilo_we = 1'b0; illegal = 1'b0; bus_err = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1; alu_src_b = 2'd2;
          if (mem_ready) begin
            ir_we = 1'b1; pc_we = 1'b1; state_d = S_DECODE;
          end else if (wait_q == TO_W'(MEM_TIMEOUT - 1)) begin
            bus_err = 1'b1; state_d = S_FETCH;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        S_DECODE: begin
          op_d = op; rt_d = rt_field; state_d = S_FETCH;
          case (op)
            OP_RTYPE: begin
              if (is_mul || is_div) begin
                md_start = 1'b1; state_d = S_MULDIV;
                md_cnt_d = is_div ? MD_W'(DIV_CYCLES - 1) : MD_W'(MUL_CYCLES - 1);
              end else begin
                state_d = S_EXEC_R;
              end
            end
            OP_J:   begin pc_we = 1'b1; pc_src = 2'd2; end
            OP_JAL: begin
              pc_we = 1'b1; pc_src = 2'd2; reg_we = 1'b1; reg_dst = 2'd2; wb_src = 2'd2;
            end
            OP_REGIMM: begin
              if (rt_field == 5'd0 || rt_field == 5'd1) state_d = S_BRANCH;
              else illegal = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: state_d = S_BRANCH;
            OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: state_d = S_EXEC_I;
            OP_LB, OP_LBU, OP_LW, OP_SB, OP_SW: state_d = S_ADDR;
            default: illegal = 1'b1;
          endcase
        end
        S_EXEC_R: begin
          // The ALU picks the operation from the funct field itself.
          alu_op = ALUOP_W'(5'b01111); reg_we = 1'b1; reg_dst = 2'd1; state_d = S_FETCH;
        end
        S_EXEC_I: begin
          alu_src_b = 2'd1; reg_we = 1'b1; state_d = S_FETCH;
          case (op_q)
            OP_SLTI:  begin alu_op = ALUOP_W'(5'b00010); ext_op = 1'b1; end
            OP_SLTIU: begin alu_op = ALUOP_W'(5'b01001); ext_op = 1'b1; end
            OP_ANDI:  alu_op = ALUOP_W'(5'b00011);
            OP_ORI:   alu_op = ALUOP_W'(5'b00101);
            OP_XORI:  alu_op = ALUOP_W'(5'b00110);
            OP_LUI:   alu_op = ALUOP_W'(5'b10000);
            default:  begin alu_op = ALUOP_W'(5'b00000); ext_op = 1'b1; end
          endcase
        end
        S_ADDR: begin
          alu_src_b = 2'd1; ext_op = 1'b1; state_d = S_MEM;
        end
        S_MEM: begin
          mem_req = 1'b1; iord = 1'b1; mem_we = is_store;
          mem_byte = (op_q == OP_LB) || (op_q == OP_LBU) || (op_q == OP_SB);
          mem_uns  = (op_q == OP_LBU);
          if (mem_ready) begin
            state_d = is_store ? S_FETCH : S_WB;
          end else if (wait_q == TO_W'(MEM_TIMEOUT - 1)) begin
            bus_err = 1'b1; state_d = S_FETCH;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        S_WB: begin
          reg_we = 1'b1; wb_src = 2'd1; state_d = S_FETCH;
        end
        S_BRANCH: begin
          pc_we = br_taken; pc_src = 2'd1; state_d = S_FETCH;
          case (op_q)
            OP_BEQ, OP_BNE: alu_op = ALUOP_W'(5'b00001);
            OP_BGTZ:        alu_op = ALUOP_W'(5'b10010);
            OP_BLEZ:        alu_op = ALUOP_W'(5'b10011);
            default:        alu_op = (rt_q == 5'd1) ? ALUOP_W'(5'b10001) : ALUOP_W'(5'b10100);
          endcase
        end
        S_MULDIV: begin
          md_busy = 1'b1;
          if (md_cnt_q == '0) begin
            hilo_we = 1'b1; state_d = S_FETCH;
          end else begin
            md_cnt_d = md_cnt_q - 1'b1;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: an instruction catalogue plus a phase-level model builds the
// expected per-cycle control trace, which is compared against the DUT every cycle.
module tb_mc_control;
  localparam int MUL_N = 4;
  localparam int DIV_N = 32;
  localparam int TO    = 15;

  localparam logic [3:0] ST_FETCH = 4'd0, ST_DEC = 4'd1, ST_EXR = 4'd2, ST_EXI = 4'd3;
  localparam logic [3:0] ST_ADDR = 4'd4, ST_MEM = 4'd5, ST_WB = 4'd6, ST_BR = 4'd7;
  localparam logic [3:0] ST_MD = 4'd8;

  localparam int K_J = 0, K_JAL = 1, K_R = 2, K_MUL = 3, K_DIV = 4, K_I = 5;
  localparam int K_LD = 6, K_ST = 7, K_BR = 8, K_ILL = 9;
  localparam int NTBL = 27;

  typedef struct packed {
    logic mem_req; logic mem_we; logic mem_byte; logic mem_uns; logic iord;
    logic ir_we; logic pc_we; logic [1:0] pc_src; logic reg_we; logic [1:0] reg_dst;
    logic [1:0] wb_src; logic [1:0] alu_src_b; logic ext_op; logic [4:0] alu_op;
    logic md_start; logic md_busy; logic hilo_we; logic illegal; logic bus_err;
    logic [3:0] st;
  } obs_t;
  localparam int W = $bits(obs_t);

  typedef struct {
    logic [5:0] op; logic [5:0] funct; logic [4:0] rt; int kind;
    logic [4:0] aluop; logic ext; logic bsel; logic uns;
  } instr_t;

  logic clk, rst;
  logic [5:0] op, funct;
  logic [4:0] rt_field;
  logic br_taken, mem_ready;
  logic mem_req, mem_we, mem_byte, mem_uns, iord, ir_we, pc_we;
  logic [1:0] pc_src, reg_dst, wb_src, alu_src_b;
  logic reg_we, ext_op, md_start, md_busy, hilo_we, illegal, bus_err;
  logic [4:0] alu_op;
  logic [3:0] state;

  logic [W-1:0] exp_q[$];
  logic         rdy_q[$];
  instr_t       tbl[NTBL];
  int           n_cmp = 0;
  int           n_fail = 0;
  int           dec_idx;
  string        tag;

  mc_control #(.ALUOP_W(5), .MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .rt_field(rt_field),
    .br_taken(br_taken), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_byte(mem_byte), .mem_uns(mem_uns), .iord(iord), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .reg_we(reg_we), .reg_dst(reg_dst), .wb_src(wb_src),
    .alu_src_b(alu_src_b), .ext_op(ext_op), .alu_op(alu_op), .md_start(md_start),
    .md_busy(md_busy), .hilo_we(hilo_we), .illegal(illegal), .bus_err(bus_err),
    .state(state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t obs();
    obs_t r;
    r.mem_req = mem_req; r.mem_we = mem_we; r.mem_byte = mem_byte; r.mem_uns = mem_uns;
    r.iord = iord; r.ir_we = ir_we; r.pc_we = pc_we; r.pc_src = pc_src; r.reg_we = reg_we;
    r.reg_dst = reg_dst; r.wb_src = wb_src; r.alu_src_b = alu_src_b; r.ext_op = ext_op;
    r.alu_op = alu_op; r.md_start = md_start; r.md_busy = md_busy; r.hilo_we = hilo_we;
    r.illegal = illegal; r.bus_err = bus_err; r.st = state;
    return r;
  endfunction

  function automatic obs_t blank(input logic [3:0] st);
    obs_t r;
    r = '0; r.st = st;
    return r;
  endfunction

  function automatic obs_t fetch_vec();
    obs_t r;
    r = blank(ST_FETCH); r.mem_req = 1'b1; r.alu_src_b = 2'd2;
    return r;
  endfunction

  function automatic instr_t mk(input logic [5:0] o, input logic [4:0] rt, input int k,
                                input logic [4:0] a, input logic e, input logic b,
                                input logic u);
    instr_t r;
    r.op = o; r.funct = 6'd0; r.rt = rt; r.kind = k; r.aluop = a; r.ext = e;
    r.bsel = b; r.uns = u;
    return r;
  endfunction

  task automatic init_tbl();
    tbl[0]  = mk(6'b001001, 5'd0, K_I, 5'b00000, 1, 0, 0);
    tbl[1]  = mk(6'b001010, 5'd0, K_I, 5'b00010, 1, 0, 0);
    tbl[2]  = mk(6'b001011, 5'd0, K_I, 5'b01001, 1, 0, 0);
    tbl[3]  = mk(6'b001100, 5'd0, K_I, 5'b00011, 0, 0, 0);
    tbl[4]  = mk(6'b001101, 5'd0, K_I, 5'b00101, 0, 0, 0);
    tbl[5]  = mk(6'b001110, 5'd0, K_I, 5'b00110, 0, 0, 0);
    tbl[6]  = mk(6'b001111, 5'd0, K_I, 5'b10000, 0, 0, 0);
    tbl[7]  = mk(6'b100011, 5'd0, K_LD, 5'd0, 0, 0, 0);
    tbl[8]  = mk(6'b100000, 5'd0, K_LD, 5'd0, 0, 1, 0);
    tbl[9]  = mk(6'b100100, 5'd0, K_LD, 5'd0, 0, 1, 1);
    tbl[10] = mk(6'b101011, 5'd0, K_ST, 5'd0, 0, 0, 0);
    tbl[11] = mk(6'b101000, 5'd0, K_ST, 5'd0, 0, 1, 0);
    tbl[12] = mk(6'b000100, 5'd0, K_BR, 5'b00001, 0, 0, 0);
    tbl[13] = mk(6'b000101, 5'd0, K_BR, 5'b00001, 0, 0, 0);
    tbl[14] = mk(6'b000110, 5'd0, K_BR, 5'b10011, 0, 0, 0);
    tbl[15] = mk(6'b000111, 5'd0, K_BR, 5'b10010, 0, 0, 0);
    tbl[16] = mk(6'b000001, 5'd1, K_BR, 5'b10001, 0, 0, 0);
    tbl[17] = mk(6'b000001, 5'd0, K_BR, 5'b10100, 0, 0, 0);
    tbl[18] = mk(6'b000010, 5'd0, K_J, 5'd0, 0, 0, 0);
    tbl[19] = mk(6'b000011, 5'd0, K_JAL, 5'd0, 0, 0, 0);
    tbl[20] = mk(6'b000000, 5'd0, K_R, 5'd0, 0, 0, 0);
    tbl[21] = mk(6'b000000, 5'd0, K_MUL, 5'd0, 0, 0, 0); tbl[21].funct = 6'b011000;
    tbl[22] = mk(6'b000000, 5'd0, K_MUL, 5'd0, 0, 0, 0); tbl[22].funct = 6'b011001;
    tbl[23] = mk(6'b000000, 5'd0, K_DIV, 5'd0, 0, 0, 0); tbl[23].funct = 6'b011010;
    tbl[24] = mk(6'b000000, 5'd0, K_DIV, 5'd0, 0, 0, 0); tbl[24].funct = 6'b011011;
    tbl[25] = mk(6'b111111, 5'd0, K_ILL, 5'd0, 0, 0, 0);
    tbl[26] = mk(6'b011100, 5'd0, K_ILL, 5'd0, 0, 0, 0);
  endtask

  task automatic push(input obs_t e, input logic r);
    exp_q.push_back(e);
    rdy_q.push_back(r);
  endtask

  task automatic push_any(input obs_t e);
    push(e, 1'($urandom_range(0, 1)));
  endtask

  // Reference model: expected trace of one instruction from its class and wait profile.
  task automatic model_instr(input instr_t ins, input logic br, input bit fto,
                             input int fw, input int mw);
    obs_t e;
    int   n;
    if (fto) begin
      for (int k = 0; k < TO; k++) begin
        e = fetch_vec(); e.bus_err = (k == TO - 1); push(e, 1'b0);
      end
    end
    for (int k = 0; k < fw; k++) push(fetch_vec(), 1'b0);
    e = fetch_vec(); e.ir_we = 1'b1; e.pc_we = 1'b1; push(e, 1'b1);
    dec_idx = exp_q.size();
    e = blank(ST_DEC);
    case (ins.kind)
      K_J:   begin e.pc_we = 1'b1; e.pc_src = 2'd2; end
      K_JAL: begin
        e.pc_we = 1'b1; e.pc_src = 2'd2; e.reg_we = 1'b1; e.reg_dst = 2'd2; e.wb_src = 2'd2;
      end
      K_MUL, K_DIV: e.md_start = 1'b1;
      K_ILL: e.illegal = 1'b1;
      default: ;
    endcase
    push_any(e);
    case (ins.kind)
      K_R: begin
        e = blank(ST_EXR); e.alu_op = 5'b01111; e.reg_we = 1'b1; e.reg_dst = 2'd1; push_any(e);
      end
      K_I: begin
        e = blank(ST_EXI); e.alu_src_b = 2'd1; e.reg_we = 1'b1; e.alu_op = ins.aluop;
        e.ext_op = ins.ext; push_any(e);
      end
      K_LD, K_ST: begin
        e = blank(ST_ADDR); e.alu_src_b = 2'd1; e.ext_op = 1'b1; push_any(e);
        e = blank(ST_MEM); e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = (ins.kind == K_ST);
        e.mem_byte = ins.bsel; e.mem_uns = ins.uns;
        if (mw < TO) begin
          for (int k = 0; k < mw; k++) push(e, 1'b0);
          push(e, 1'b1);
          if (ins.kind == K_LD) begin
            e = blank(ST_WB); e.reg_we = 1'b1; e.wb_src = 2'd1; push_any(e);
          end
        end else begin
          for (int k = 0; k < TO - 1; k++) push(e, 1'b0);
          e.bus_err = 1'b1; push(e, 1'b0);
        end
      end
      K_BR: begin
        e = blank(ST_BR); e.alu_op = ins.aluop; e.pc_we = br; e.pc_src = 2'd1; push_any(e);
      end
      K_MUL, K_DIV: begin
        n = (ins.kind == K_MUL) ? MUL_N : DIV_N;
        for (int k = 0; k < n; k++) begin
          e = blank(ST_MD); e.md_busy = 1'b1; e.hilo_we = (k == n - 1); push_any(e);
        end
      end
      default: ;
    endcase
  endtask

  // Driver + scoreboard: one comparison per cycle at the falling edge.
  task automatic drive_trace(input int max_cyc);
    logic [W-1:0] exp_v;
    obs_t         got;
    int           cyc;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < max_cyc) begin
      exp_v = exp_q.pop_front();
      mem_ready = rdy_q.pop_front();
      if (cyc > dec_idx) begin
        op = 6'($urandom_range(0, 63)); funct = 6'($urandom_range(0, 63));
        rt_field = 5'($urandom_range(0, 31));
      end
      @(negedge clk);
      got = obs();
      n_cmp++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp_v);
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic setup_instr(input int idx, input logic br, input bit fto, input int fw,
                             input int mw, input string tag_s);
    instr_t ins;
    ins = tbl[idx];
    if (ins.kind == K_R) begin
      ins.funct = 6'($urandom_range(0, 63));
      if (ins.funct[5:2] == 4'b0110) ins.funct = 6'b100001;
    end else if (ins.kind != K_MUL && ins.kind != K_DIV) begin
      ins.funct = 6'($urandom_range(0, 63));
    end
    if (ins.op != 6'b000001) ins.rt = 5'($urandom_range(0, 31));
    op = ins.op; funct = ins.funct; rt_field = ins.rt; br_taken = br;
    tag = tag_s;
    model_instr(ins, br, fto, fw, mw);
  endtask

  task automatic run_instr(input int idx, input logic br, input bit fto, input int fw,
                           input int mw, input string tag_s);
    setup_instr(idx, br, fto, fw, mw, tag_s);
    drive_trace(1000);
  endtask

  task automatic check_now(input string name, input obs_t want);
    obs_t got;
    got = obs();
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Assert reset mid-instruction, check the async clear, then release on a fresh cycle.
  task automatic reset_mid(input string name);
    obs_t z;
    z = '0;
    rst = 1'b1; #1;
    check_now({name, "_async"}, z);
    mem_ready = 1'b1;
    @(negedge clk);
    check_now({name, "_held"}, z);
    exp_q.delete(); rdy_q.delete();
    mem_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; #1;
    check_now({name, "_release"}, fetch_vec());
  endtask

  task automatic test_reset();
    obs_t z;
    z = '0;
    rst = 1'b1; mem_ready = 1'b1; br_taken = 1'b1;
    op = 6'b001001; funct = 6'd0; rt_field = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_now("reset_outputs", z);
    @(negedge clk);
    check_now("reset_outputs_2", z);
    mem_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; #1;
    check_now("reset_release_fetch", fetch_vec());
  endtask

  task automatic test_addiu();       run_instr(0, 1'b0, 0, 0, 0, "addiu"); endtask
  task automatic test_lw_wait();     run_instr(7, 1'b0, 0, 0, 3, "lw_wait3"); endtask

  task automatic test_beq();
    run_instr(12, 1'b1, 0, 0, 0, "beq_taken");
    run_instr(12, 1'b0, 0, 1, 0, "beq_not_taken");
  endtask

  task automatic test_div();         run_instr(23, 1'b0, 0, 0, 0, "div"); endtask
  task automatic test_illegal();     run_instr(25, 1'b1, 0, 0, 0, "illegal"); endtask
  task automatic test_fetch_timeout(); run_instr(0, 1'b0, 1, 0, 0, "fetch_timeout"); endtask

  task automatic test_mem_timeout();
    run_instr(10, 1'b0, 0, 0, TO - 1, "sw_ready_on_last");
    run_instr(7, 1'b0, 0, 0, TO, "lw_bus_err");
  endtask

  task automatic test_each_instr();
    for (int i = 0; i < NTBL; i++)
      run_instr(i, 1'($urandom_range(0, 1)), 0, $urandom_range(0, 2), $urandom_range(0, 2),
                "catalogue");
  endtask

  task automatic test_reset_mid();
    obs_t got;
    setup_instr(23, 1'b0, 0, 0, 0, "rst_mid_muldiv_pre");
    drive_trace(8);
    got = obs();
    n_cmp++;
    if (got.st !== ST_MD || got.md_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_muldiv_pre: got state %0d busy %b expected 8 1", got.st, got.md_busy);
    end
    reset_mid("rst_mid_muldiv");
    setup_instr(7, 1'b0, 0, 0, 10, "rst_mid_mem_pre");
    drive_trace(5);
    mem_ready = 1'b0; #1;
    got = obs();
    n_cmp++;
    if (got.st !== ST_MEM || got.mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_mem_pre: got state %0d req %b expected 5 1", got.st, got.mem_req);
    end
    reset_mid("rst_mid_mem");
    run_instr(19, 1'b0, 0, 0, 0, "jal_after_reset");
  endtask

  task automatic test_back_to_back();
    int r, fw, mw;
    bit fto;
    for (int i = 0; i < 80; i++) begin
      r  = $urandom_range(0, 9);
      mw = (r < 8) ? $urandom_range(0, 3) : ((r == 8) ? TO - 1 : TO);
      fw = $urandom_range(0, 2);
      fto = ($urandom_range(0, 19) == 0);
      run_instr($urandom_range(0, NTBL - 1), 1'($urandom_range(0, 1)), fto, fw, mw, "b2b");
    end
  endtask

  initial begin
    init_tbl();
    test_reset();
    test_addiu();
    test_lw_wait();
    test_beq();
    test_div();
    test_illegal();
    test_fetch_timeout();
    test_mem_timeout();
    test_each_instr();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
